// File: rtl/apb_axil_bridge.sv
// APB3 completer that forwards each APB transfer as a single AXI4-Lite master transaction.
// One transfer in flight at a time; a response timeout keeps the APB side from hanging.
module apb_axil_bridge #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          TIMEOUT    = 256,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,

    input  logic [ADDR_WIDTH-1:0] s_apb_paddr,
    input  logic                  s_apb_psel,
    input  logic                  s_apb_penable,
    input  logic                  s_apb_pwrite,
    input  logic [31:0]           s_apb_pwdata,
    output logic                  s_apb_pready,
    output logic [31:0]           s_apb_prdata,
    output logic                  s_apb_pslverr,

    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    // state   | meaning
    // IDLE    | waiting for an APB setup phase
    // WR_REQ  | AW and/or W still waiting for their handshakes
    // WR_RESP | bready high, waiting for the write response
    // RD_REQ  | arvalid waiting for its handshake
    // RD_RESP | rready high, waiting for read data
    // DONE    | one-cycle pready for a completed transfer
    // DRAIN   | APB already errored by timeout; finishing the orphaned AXI transaction
    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, DRAIN
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_write;
    logic             timeout_hit;
    logic             aw_left;
    logic             w_left;
    logic             ar_left;
    logic             unused_resp;

    assign m_axi_wstrb = 4'hF;
    assign unused_resp = m_axi_bresp[0] ^ m_axi_rresp[0];

    // cnt == TIMEOUT-1 at the edge means the count reaches TIMEOUT on this cycle
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_TERM);

    // valids still outstanding after the current edge
    assign aw_left = m_axi_awvalid & ~m_axi_awready;
    assign w_left  = m_axi_wvalid  & ~m_axi_wready;
    assign ar_left = m_axi_arvalid & ~m_axi_arready;

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state         <= IDLE;
            cnt           <= '0;
            is_write      <= 1'b0;
            s_apb_pready  <= 1'b0;
            s_apb_pslverr <= 1'b0;
            s_apb_prdata  <= '0;
            m_axi_awaddr  <= '0;
            m_axi_araddr  <= '0;
            m_axi_wdata   <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_apb_psel && !s_apb_penable) begin
                        m_axi_awaddr <= s_apb_paddr;
                        m_axi_araddr <= s_apb_paddr;
                        m_axi_wdata  <= s_apb_pwdata;
                        is_write     <= s_apb_pwrite;
                        cnt          <= '0;
                        if (s_apb_pwrite) begin
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            m_axi_arvalid <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    cnt           <= cnt + CNT_W'(1);
                    m_axi_awvalid <= aw_left;
                    m_axi_wvalid  <= w_left;
                    if (timeout_hit) begin
                        s_apb_pready  <= 1'b1;
                        s_apb_pslverr <= 1'b1;
                        state         <= DRAIN;
                    end else if (!aw_left && !w_left) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    cnt <= cnt + CNT_W'(1);
                    // a response landing on the timeout cycle still wins
                    if (m_axi_bvalid) begin
                        m_axi_bready  <= 1'b0;
                        s_apb_pslverr <= m_axi_bresp[1];
                        s_apb_pready  <= 1'b1;
                        state         <= DONE;
                    end else if (timeout_hit) begin
                        s_apb_pready  <= 1'b1;
                        s_apb_pslverr <= 1'b1;
                        state         <= DRAIN;
                    end
                end
                RD_REQ: begin
                    cnt           <= cnt + CNT_W'(1);
                    m_axi_arvalid <= ar_left;
                    if (timeout_hit) begin
                        s_apb_pready  <= 1'b1;
                        s_apb_pslverr <= 1'b1;
                        s_apb_prdata  <= ERR_RDATA;
                        state         <= DRAIN;
                    end else if (!ar_left) begin
                        m_axi_rready <= 1'b1;
                        state        <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (m_axi_rvalid) begin
                        m_axi_rready  <= 1'b0;
                        s_apb_prdata  <= m_axi_rdata;
                        s_apb_pslverr <= m_axi_rresp[1];
                        s_apb_pready  <= 1'b1;
                        state         <= DONE;
                    end else if (timeout_hit) begin
                        s_apb_pready  <= 1'b1;
                        s_apb_pslverr <= 1'b1;
                        s_apb_prdata  <= ERR_RDATA;
                        state         <= DRAIN;
                    end
                end
                DONE: begin
                    s_apb_pready  <= 1'b0;
                    s_apb_pslverr <= 1'b0;
                    state         <= IDLE;
                end
                DRAIN: begin
                    s_apb_pready  <= 1'b0;
                    s_apb_pslverr <= 1'b0;
                    m_axi_awvalid <= aw_left;
                    m_axi_wvalid  <= w_left;
                    m_axi_arvalid <= ar_left;
                    if ((m_axi_bready && m_axi_bvalid) || (m_axi_rready && m_axi_rvalid)) begin
                        m_axi_bready <= 1'b0;
                        m_axi_rready <= 1'b0;
                        state        <= IDLE;
                    end else if (!m_axi_bready && !m_axi_rready && !aw_left && !w_left && !ar_left) begin
                        m_axi_bready <= is_write;
                        m_axi_rready <= ~is_write;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_axil_bridge.sv
// Self-checking bench for apb_axil_bridge: APB initiator tasks, a delay-configurable AXI-Lite
// target, and a transfer-level model predicting data, error and access length.
module tb_apb_axil_bridge;
    localparam int          TMO      = 8;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [31:0] s_apb_paddr;
    logic        s_apb_psel;
    logic        s_apb_penable;
    logic        s_apb_pwrite;
    logic [31:0] s_apb_pwdata;
    logic        s_apb_pready;
    logic [31:0] s_apb_prdata;
    logic        s_apb_pslverr;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int tests = 0;
    int fails = 0;

    // target configuration, set per transfer
    int         cfg_da, cfg_dw, cfg_db, cfg_dar, cfg_dr;
    logic [1:0] cfg_bresp, cfg_rresp;

    // target observations
    logic [31:0] tgt_mem [logic [31:0]];
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0;

    // reference model
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] model_prdata = '0;
    int          exp_aw = 0, exp_b = 0, exp_ar = 0;

    apb_axil_bridge #(.ADDR_WIDTH(32), .TIMEOUT(TMO), .ERR_RDATA(ERR_WORD)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (aresetn),
        .s_apb_paddr   (s_apb_paddr),
        .s_apb_psel    (s_apb_psel),
        .s_apb_penable (s_apb_penable),
        .s_apb_pwrite  (s_apb_pwrite),
        .s_apb_pwdata  (s_apb_pwdata),
        .s_apb_pready  (s_apb_pready),
        .s_apb_prdata  (s_apb_prdata),
        .s_apb_pslverr (s_apb_pslverr),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt_word(a);
    endfunction

    // AXI-Lite target: ready/response after a configured number of cycles of valid/ready
    initial begin
        logic        aw_v_q = 1'b0, w_v_q = 1'b0, ar_v_q = 1'b0, b_rdy_q = 1'b0, r_rdy_q = 1'b0;
        logic [31:0] aw_a_q = '0, w_d_q = '0, ar_a_q = '0, pend_a = '0, pend_d = '0, rd_addr = '0;
        logic        have_aw = 1'b0, have_w = 1'b0;
        logic        aw_hs, w_hs, ar_hs, b_hs, r_hs;
        int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00; m_axi_rdata = '0;
        forever begin
            @(negedge clk);
            aw_hs = aw_v_q && m_axi_awready;
            w_hs  = w_v_q && m_axi_wready;
            ar_hs = ar_v_q && m_axi_arready;
            b_hs  = m_axi_bvalid && b_rdy_q;
            r_hs  = m_axi_rvalid && r_rdy_q;
            if (aw_v_q && !aw_hs) chk("awaddr_stable", {m_axi_awvalid, m_axi_awaddr[30:0]}, {1'b1, aw_a_q[30:0]});
            if (w_v_q && !w_hs)   chk("wdata_stable", {31'b0, m_axi_wvalid}, 32'd1);
            if (w_v_q && !w_hs)   chk("wdata_value", m_axi_wdata, w_d_q);
            if (ar_v_q && !ar_hs) chk("araddr_stable", {m_axi_arvalid, m_axi_araddr[30:0]}, {1'b1, ar_a_q[30:0]});
            if (m_axi_wvalid === 1'b1) chk("wstrb", {28'b0, m_axi_wstrb}, 32'hF);
            if (aw_hs) begin n_aw++; pend_a = aw_a_q; have_aw = 1'b1; end
            if (w_hs)  begin n_w++;  pend_d = w_d_q;  have_w  = 1'b1; end
            if (have_aw && have_w) begin
                tgt_mem[pend_a] = pend_d;
                last_awaddr = pend_a;
                last_wdata  = pend_d;
                have_aw = 1'b0;
                have_w  = 1'b0;
            end
            if (ar_hs) begin n_ar++; rd_addr = ar_a_q; end
            if (b_hs) begin n_b++; m_axi_bvalid = 1'b0; end
            if (r_hs) begin n_r++; m_axi_rvalid = 1'b0; end

            if (m_axi_awvalid === 1'b1) begin m_axi_awready = (aw_cnt >= cfg_da); aw_cnt++; end
            else begin m_axi_awready = 1'b0; aw_cnt = 0; end
            if (m_axi_wvalid === 1'b1) begin m_axi_wready = (w_cnt >= cfg_dw); w_cnt++; end
            else begin m_axi_wready = 1'b0; w_cnt = 0; end
            if (m_axi_arvalid === 1'b1) begin m_axi_arready = (ar_cnt >= cfg_dar); ar_cnt++; end
            else begin m_axi_arready = 1'b0; ar_cnt = 0; end
            if (!m_axi_bvalid) begin
                if (m_axi_bready === 1'b1) begin
                    if (b_cnt >= cfg_db) begin m_axi_bvalid = 1'b1; m_axi_bresp = cfg_bresp; b_cnt = 0; end
                    else b_cnt++;
                end else b_cnt = 0;
            end
            if (!m_axi_rvalid) begin
                if (m_axi_rready === 1'b1) begin
                    if (r_cnt >= cfg_dr) begin
                        m_axi_rvalid = 1'b1;
                        m_axi_rresp  = cfg_rresp;
                        m_axi_rdata  = tgt_mem.exists(rd_addr) ? tgt_mem[rd_addr] : dflt_word(rd_addr);
                        r_cnt = 0;
                    end else r_cnt++;
                end else r_cnt = 0;
            end
            aw_v_q = m_axi_awvalid; aw_a_q = m_axi_awaddr;
            w_v_q  = m_axi_wvalid;  w_d_q  = m_axi_wdata;
            ar_v_q = m_axi_arvalid; ar_a_q = m_axi_araddr;
            b_rdy_q = m_axi_bready; r_rdy_q = m_axi_rready;
        end
    end

    task automatic set_cfg(input int da, input int dw, input int db, input int dar, input int dr,
                           input logic [1:0] br, input logic [1:0] rr);
        cfg_da = da; cfg_dw = dw; cfg_db = db; cfg_dar = dar; cfg_dr = dr;
        cfg_bresp = br; cfg_rresp = rr;
    endtask

    task automatic check_quiet_outputs(input string tag);
        chk({tag, "_ctrl"}, {25'b0, s_apb_pready, s_apb_pslverr, m_axi_awvalid, m_axi_wvalid,
                             m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'b0);
        chk({tag, "_prdata"}, s_apb_prdata, 32'b0);
        chk({tag, "_awaddr"}, m_axi_awaddr, 32'b0);
        chk({tag, "_araddr"}, m_axi_araddr, 32'b0);
        chk({tag, "_wdata"}, m_axi_wdata, 32'b0);
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            output logic [31:0] rd, output logic err, output int cyc);
        @(negedge clk);
        s_apb_psel = 1'b1; s_apb_penable = 1'b0; s_apb_pwrite = wr;
        s_apb_paddr = addr; s_apb_pwdata = data;
        @(negedge clk);
        s_apb_penable = 1'b1;
        cyc = 1;
        while (s_apb_pready !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        rd  = s_apb_prdata;
        err = s_apb_pslverr;
        @(posedge clk);
        #1;
        s_apb_psel = 1'b0; s_apb_penable = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int guard = 0;
        while (quiet < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
            if ((m_axi_awvalid | m_axi_wvalid | m_axi_arvalid | m_axi_bready | m_axi_rready |
                 m_axi_bvalid | m_axi_rvalid | s_apb_pready) === 1'b0) quiet++;
            else quiet = 0;
        end
        chk("drain_to_idle", 32'(quiet >= 3), 32'd1);
    endtask

    task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic probe);
        logic [31:0] got_rd, exp_rd;
        logic        got_err, exp_err;
        int          got_cyc, exp_cyc;
        exp_cyc = wr ? 3 + ((cfg_da > cfg_dw) ? cfg_da : cfg_dw) + cfg_db : 3 + cfg_dar + cfg_dr;
        if (exp_cyc > TMO + 1) begin
            exp_cyc = TMO + 1;
            exp_err = 1'b1;
            exp_rd  = wr ? model_prdata : ERR_WORD;
        end else begin
            exp_err = wr ? cfg_bresp[1] : cfg_rresp[1];
            exp_rd  = wr ? model_prdata : ref_word(addr);
        end
        apb_xfer(wr, addr, data, got_rd, got_err, got_cyc);
        chk("access_cycles", 32'(got_cyc), 32'(exp_cyc));
        chk("pslverr", {31'b0, got_err}, {31'b0, exp_err});
        chk("prdata", got_rd, exp_rd);
        @(negedge clk);
        chk("pready_one_cycle", {31'b0, s_apb_pready}, 32'b0);
        chk("pslverr_cleared", {31'b0, s_apb_pslverr}, 32'b0);
        if (probe) begin
            // setup presented while draining must not be captured
            s_apb_psel = 1'b1; s_apb_penable = 1'b0; s_apb_pwrite = 1'b1;
            s_apb_paddr = 32'h0000_0200; s_apb_pwdata = 32'h1111_2222;
            repeat (4) begin
                @(negedge clk);
                s_apb_penable = 1'b1;
                chk("drain_no_pready", {31'b0, s_apb_pready}, 32'b0);
                chk("drain_no_awvalid", {31'b0, m_axi_awvalid}, 32'b0);
            end
            s_apb_psel = 1'b0; s_apb_penable = 1'b0;
        end
        model_prdata = exp_rd;
        if (wr) begin ref_mem[addr] = data; exp_aw++; exp_b++; end
        else exp_ar++;
        wait_idle();
        chk("aw_count", 32'(n_aw), 32'(exp_aw));
        chk("w_count", 32'(n_w), 32'(exp_aw));
        chk("b_count", 32'(n_b), 32'(exp_b));
        chk("ar_count", 32'(n_ar), 32'(exp_ar));
        chk("r_count", 32'(n_r), 32'(exp_ar));
        if (wr) begin
            chk("aw_addr", last_awaddr, addr);
            chk("w_data", last_wdata, data);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        s_apb_psel = 1'b0; s_apb_penable = 1'b0; s_apb_pwrite = 1'b0;
        s_apb_paddr = '0; s_apb_pwdata = '0;
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check_quiet_outputs("reset");
        chk("wstrb_const", {28'b0, m_axi_wstrb}, 32'hF);
        @(negedge clk);
        aresetn = 1'b1;

        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00); run_xfer(1'b1, 32'h40, 32'hA5A5_0001, 1'b0);
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00); run_xfer(1'b1, 32'h1000, 32'h1234_5678, 1'b0);
        set_cfg(0, 0, 0, 4, 0, 2'b00, 2'b00); run_xfer(1'b0, 32'h1000, 32'h0, 1'b0);
        set_cfg(4, 0, 0, 0, 0, 2'b00, 2'b00); run_xfer(1'b1, 32'h44, 32'h0F0F_1234, 1'b0);
        set_cfg(0, 0, 1, 0, 0, 2'b10, 2'b00); run_xfer(1'b1, 32'h48, 32'hCAFE_0048, 1'b0);
        set_cfg(0, 0, 0, 0, 2, 2'b00, 2'b11); run_xfer(1'b0, 32'h1000, 32'h0, 1'b0);
        // response on the last cycle before the timeout, then one cycle too late
        set_cfg(0, 0, 0, 6, 0, 2'b00, 2'b00); run_xfer(1'b0, 32'h40, 32'h0, 1'b0);
        set_cfg(5, 0, 2, 0, 0, 2'b00, 2'b00); run_xfer(1'b1, 32'h4C, 32'h7777_0000, 1'b0);
        set_cfg(0, 0, 0, 20, 0, 2'b00, 2'b00); run_xfer(1'b0, 32'h44, 32'h0, 1'b1);
        set_cfg(0, 0, 0, 0, 0, 2'b00, 2'b00); run_xfer(1'b0, 32'h4C, 32'h0, 1'b0);

        // reset while waiting for the write response
        set_cfg(0, 0, 6, 0, 0, 2'b00, 2'b00);
        @(negedge clk);
        s_apb_psel = 1'b1; s_apb_penable = 1'b0; s_apb_pwrite = 1'b1;
        s_apb_paddr = 32'h80; s_apb_pwdata = 32'h0BAD_F00D;
        @(negedge clk);
        s_apb_penable = 1'b1;
        for (int k = 0; k < 20 && m_axi_bready !== 1'b1; k++) @(negedge clk);
        chk("reached_wr_resp", {31'b0, m_axi_bready}, 32'd1);
        aresetn = 1'b0;
        @(posedge clk);
        #1;
        check_quiet_outputs("midreset");
        @(negedge clk);
        aresetn = 1'b1; s_apb_psel = 1'b0; s_apb_penable = 1'b0;
        ref_mem[32'h80] = 32'h0BAD_F00D;
        exp_aw++;
        model_prdata = '0;
        wait_idle();
        set_cfg(0, 0, 0, 1, 1, 2'b00, 2'b00); run_xfer(1'b0, 32'h80, 32'h0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            set_cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            run_xfer(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 7)), $urandom, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/apb_axil_bridge.md
Name: apb_axil_bridge

Overview:
- APB3 completer that converts each APB transfer into a single AXI4-Lite master transaction; the inverse of our AXI-Lite-to-APB bridge.
- Lets an APB-only initiator (e.g. a debug/config sequencer) reach AXI-Lite register space in the NVDLA subsystem.
- Exactly one transfer is in flight at a time.
- A response timeout guarantees the APB bus never hangs on a silent AXI target.

Parameters:
- ADDR_WIDTH, 32, width of paddr and of m_axi_awaddr/m_axi_araddr.
- TIMEOUT, 256, cycles to wait for AXI completion before erroring the APB transfer; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF, value returned on prdata for a timed-out read.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  synchronous active-low reset.
- s_apb_paddr  in  ADDR_WIDTH  APB address.
- s_apb_psel  in  1  APB select.
- s_apb_penable  in  1  APB enable.
- s_apb_pwrite  in  1  1 = write.
- s_apb_pwdata  in  32  write data.
- s_apb_pready  out  1  transfer complete.
- s_apb_prdata  out  32  read data.
- s_apb_pslverr  out  1  transfer error.
- m_axi_awaddr  out  ADDR_WIDTH  write address.
- m_axi_awvalid  out  1  write address valid.
- m_axi_awready  in  1  write address ready.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  tied to 4'hF.
- m_axi_wvalid  out  1  write data valid.
- m_axi_wready  in  1  write data ready.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid  in  1  write response valid.
- m_axi_bready  out  1  write response ready.
- m_axi_araddr  out  ADDR_WIDTH  read address.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.

Behaviour:
- Reset: while s_axi_aresetn=0 at a clock edge, the following are all 0 from the next cycle:
  - APB: pready, pslverr, prdata.
  - AXI control: all AXI valid/ready outputs.
  - AXI payload: awaddr, araddr, wdata.
  - Internal: timeout counter.
  - FSM goes to IDLE.
- Reset mid-transaction abandons the transaction with no drain.
- All outputs are registered.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, DRAIN.
- IDLE:
  - On psel=1 && penable=0 (setup phase), capture paddr, pwrite and pwdata into awaddr/araddr/wdata.
  - Next state is WR_REQ if pwrite=1, else RD_REQ.
  - psel=1 && penable=1 seen in IDLE (no prior setup) is ignored; pready stays 0.
- WR_REQ:
  - awvalid and wvalid both go high on entry.
  - Each drops on the cycle after its own handshake (valid && ready sampled high). The two handshakes may occur in either order or in the same cycle.
  - awvalid/wvalid and payload are never changed before their handshake.
  - When both handshakes are complete, go to WR_RESP with bready=1.
- WR_RESP:
  - On bvalid=1: bready drops next cycle and pslverr <= bresp[1] (SLVERR and DECERR both map to 1).
  - Go to DONE.
- RD_REQ:
  - arvalid=1 until handshaked, then RD_RESP with rready=1.
- RD_RESP:
  - On rvalid=1: prdata <= rdata, pslverr <= rresp[1], rready drops.
  - Go to DONE.
- DONE:
  - pready=1 for exactly one cycle, then IDLE.
  - prdata holds its value until the next read completes.
  - pslverr is meaningful only while pready=1 and is cleared on leaving DONE.
- Minimum access-phase length:
  - Setup captured at T0; AXI valids high at T1.
  - Ready/response at T1/T2 gives pready at T3.
  - Result: 3 access cycles. A new setup phase is accepted only in IDLE.
- Timeout:
  - Counter clears on leaving IDLE and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - If TIMEOUT!=0 and the count reaches TIMEOUT: pready=1 and pslverr=1 for one cycle; prdata=ERR_RDATA for reads, prdata unchanged for writes.
  - Then enter DRAIN.
- DRAIN:
  - Keeps unfinished valids asserted until their handshakes complete.
  - Then asserts bready/rready and discards the response.
  - Returns to IDLE.
  - A setup phase arriving during DRAIN is not captured; its access phase stalls with pready=0 until the bridge is back in IDLE and a fresh setup is seen.
  - The bridge relies on the APB initiator re-presenting the setup phase (psel with penable=0) after a timeout.
- psel deasserting mid-transfer (APB protocol violation): the AXI transaction still completes and the pready pulse is still produced.
- m_axi_wstrb is constant 4'hF.

Test Plan:
- Write, OKAY: paddr=0x40, pwdata=0xA5A5_0001; awready=wready=1 immediately, bvalid one cycle after bready -> AW/W carry 0x40/0xA5A5_0001, wstrb=0xF, pready one cycle, pslverr=0, access phase 3 cycles.
- Read, OKAY: paddr=0x1000; arready delayed 4 cycles; rdata=0x1234_5678, rresp=0 -> arvalid held 4 cycles with stable araddr, prdata=0x1234_5678, pslverr=0.
- Staggered write: wready at T1, awready at T5 -> wvalid drops at T2, awvalid drops at T6, bready rises at T6, no duplicate handshake.
- Error responses: bresp=2'b10 on a write -> pslverr=1; rresp=2'b11 on a read -> pslverr=1; prdata=rdata on the read.
- Timeout: TIMEOUT=8, read with arready stuck 0 -> pready and pslverr high 8 cycles after RD_REQ entry, prdata=0xDEADBEEF; arready then released -> arvalid handshakes, rready accepts the late rvalid, return to IDLE, next transfer completes normally.
- Reset mid-operation: aresetn=0 while in WR_RESP -> next cycle all valids, bready, pready=0, FSM in IDLE; a following read completes correctly.
